// File: rtl/mio_counter3_if.sv
// Bus-side signal bundle for the three-channel MIO timer.
// The master is the bus decoder; the slave is the timer peripheral.
interface mio_counter3_if;
    logic        counter_we;
    logic [1:0]  addr;
    logic [31:0] Peripheral_in;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    modport master (
        output counter_we,
        output addr,
        output Peripheral_in,
        input  counter_out,
        input  counter0_out,
        input  counter1_out,
        input  counter2_out
    );

    modport slave (
        input  counter_we,
        input  addr,
        input  Peripheral_in,
        output counter_out,
        output counter0_out,
        output counter1_out,
        output counter2_out
    );
endinterface

// File: rtl/mio_counter3.sv
// Three-channel programmable timer: one-shot, periodic pulse and square-wave
// modes, driven by a shared free-running prescaler tick.
module mio_counter3 #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    mio_counter3_if.slave   bus
);
    localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
    localparam logic [1:0]  MODE_PER = 2'b01;
    localparam logic [1:0]  MODE_SQR = 2'b10;

    logic [15:0]      pre_q, pre_d;
    logic             tick;
    logic [2:0][31:0] reload_q, reload_d;
    logic [2:0][31:0] count_q, count_d;
    logic [2:0]       out_q, out_d;
    logic [10:0]      ctrl_q, ctrl_d;
    logic             ctrl_wr;
    logic [31:0]      rdata;

    always_comb begin
        tick     = (pre_q == PRE_MAX);
        pre_d    = tick ? 16'd0 : pre_q + 16'd1;
        reload_d = reload_q;
        count_d  = count_q;
        out_d    = out_q;
        ctrl_wr  = bus.counter_we && (bus.addr == 2'b11);
        ctrl_d   = ctrl_wr ? (bus.Peripheral_in[10:0] & 11'h777) : ctrl_q;

        for (int n = 0; n < 3; n++) begin
            if (bus.counter_we && (bus.addr == 2'(n))) begin
                reload_d[n] = bus.Peripheral_in;
                count_d[n]  = bus.Peripheral_in;
                out_d[n]    = 1'b0;
            end else if (tick && ctrl_q[4*n+2]) begin
                // Counting uses the control value in effect before this edge.
                if (ctrl_q[4*n +: 2] == MODE_PER || ctrl_q[4*n +: 2] == MODE_SQR) begin
                    if (count_q[n] > 32'd1) begin
                        count_d[n] = count_q[n] - 32'd1;
                        if (ctrl_q[4*n +: 2] == MODE_PER) begin
                            out_d[n] = 1'b0;
                        end
                    end else if (reload_q[n] != 32'd0) begin
                        count_d[n] = reload_q[n];
                        out_d[n]   = (ctrl_q[4*n +: 2] == MODE_PER) ? 1'b1 : ~out_q[n];
                    end
                end else if (count_q[n] != 32'd0) begin
                    count_d[n] = count_q[n] - 32'd1;
                    if (count_q[n] == 32'd1) begin
                        out_d[n] = 1'b1;
                    end
                end
            end

            if (ctrl_wr && (ctrl_d[4*n +: 2] != ctrl_q[4*n +: 2])) begin
                out_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            reload_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            pre_q    <= pre_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            out_q    <= out_d;
            ctrl_q   <= ctrl_d;
        end
    end

    // Control readback carries the live channel outputs in bits [15:13].
    always_comb begin
        case (bus.addr)
            2'b00:   rdata = count_q[0];
            2'b01:   rdata = count_q[1];
            2'b10:   rdata = count_q[2];
            default: rdata = {16'h0000, out_q, 2'b00, ctrl_q};
        endcase
    end

    assign bus.counter_out  = rdata;
    assign bus.counter0_out = out_q[0];
    assign bus.counter1_out = out_q[1];
    assign bus.counter2_out = out_q[2];
endmodule

// File: tb/tb_mio_counter3.sv
// Bench for mio_counter3: directed scenarios plus randomized traffic on a
// PRESCALE=1 and a PRESCALE=4 instance, checked against a reference model.
module tb_mio_counter3;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mio_counter3_if b0 ();
    mio_counter3_if b1 ();

    mio_counter3 #(.PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mio_counter3 #(.PRESCALE(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_reload [2][3];
    logic [31:0] m_count  [2][3];
    logic [2:0]  m_out    [2];
    logic [10:0] m_ctrl   [2];
    int          m_pre    [2];
    int          m_p      [2] = '{1, 4};

    task automatic model_edge();
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic        tick;
        logic [10:0] nc;
        logic [1:0]  md;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin we = b0.counter_we; a = b0.addr; d = b0.Peripheral_in; end
            else        begin we = b1.counter_we; a = b1.addr; d = b1.Peripheral_in; end
            if (rst) begin
                for (int n = 0; n < 3; n++) begin
                    m_reload[i][n] = 0;
                    m_count[i][n]  = 0;
                end
                m_out[i]  = 0;
                m_ctrl[i] = 0;
                m_pre[i]  = 0;
                continue;
            end
            tick     = (m_pre[i] == m_p[i] - 1);
            m_pre[i] = (m_pre[i] + 1) % m_p[i];
            for (int n = 0; n < 3; n++) begin
                md = m_ctrl[i][4*n +: 2];
                if (we && a == 2'(n)) begin
                    m_reload[i][n] = d;
                    m_count[i][n]  = d;
                    m_out[i][n]    = 1'b0;
                end else if (tick && m_ctrl[i][4*n+2]) begin
                    if (md == 2'b01 || md == 2'b10) begin
                        if (m_count[i][n] > 1) begin
                            m_count[i][n] = m_count[i][n] - 1;
                            if (md == 2'b01) m_out[i][n] = 1'b0;
                        end else if (m_reload[i][n] != 0) begin
                            m_count[i][n] = m_reload[i][n];
                            m_out[i][n]   = (md == 2'b01) ? 1'b1 : !m_out[i][n];
                        end
                    end else begin
                        if (m_count[i][n] == 1) m_out[i][n] = 1'b1;
                        if (m_count[i][n] != 0) m_count[i][n] = m_count[i][n] - 1;
                    end
                end
            end
            if (we && a == 2'b11) begin
                nc = d[10:0] & 11'h777;
                for (int n = 0; n < 3; n++)
                    if (nc[4*n +: 2] != m_ctrl[i][4*n +: 2]) m_out[i][n] = 1'b0;
                m_ctrl[i] = nc;
            end
        end
    endtask

    function automatic logic [31:0] m_read(int i, logic [1:0] a);
        if (a == 2'b11) return {16'h0000, m_out[i], 2'b00, m_ctrl[i]};
        return m_count[i][a];
    endfunction

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // ---------------- accessors / drivers ----------------
    function automatic logic [31:0] get_rd(int i);
        return (i == 0) ? b0.counter_out : b1.counter_out;
    endfunction

    function automatic logic [2:0] get_out(int i);
        if (i == 0) return {b0.counter2_out, b0.counter1_out, b0.counter0_out};
        return {b1.counter2_out, b1.counter1_out, b1.counter0_out};
    endfunction

    task automatic set_addr(int i, logic [1:0] a);
        if (i == 0) b0.addr = a; else b1.addr = a;
        #1;
    endtask

    // Called in the low clock phase; returns just after the following negedge.
    task automatic wr(int i, logic [1:0] a, logic [31:0] d);
        if (i == 0) begin b0.counter_we = 1'b1; b0.addr = a; b0.Peripheral_in = d; end
        else        begin b1.counter_we = 1'b1; b1.addr = a; b1.Peripheral_in = d; end
        @(posedge clk);
        @(negedge clk);
        b0.counter_we = 1'b0;
        b1.counter_we = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        b0.counter_we = 1'b1; b0.addr = 2'($urandom_range(0, 3)); b0.Peripheral_in = $urandom;
        b1.counter_we = 1'b1; b1.addr = 2'($urandom_range(0, 3)); b1.Peripheral_in = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b0.counter_we = 1'b0;
        b1.counter_we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            set_addr(0, 2'(a));
            set_addr(1, 2'(a));
            n_cmp++;
            if (b0.counter_out !== 32'h0) begin
                n_bad++; $display("FAIL reset_read0 addr=%0d: got %h expected 0", a, b0.counter_out);
            end
            n_cmp++;
            if (b1.counter_out !== 32'h0) begin
                n_bad++; $display("FAIL reset_read1 addr=%0d: got %h expected 0", a, b1.counter_out);
            end
        end
        n_cmp++;
        if ({get_out(1), get_out(0)} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outs: got %b expected 000000", {get_out(1), get_out(0)});
        end
    endtask

    task automatic test_oneshot();
        wr(0, 2'b11, 32'h004);
        wr(0, 2'b00, 32'd5);
        for (int i = 0; i <= 5; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'(5 - i) || b0.counter0_out !== (i == 5)) begin
                n_bad++;
                $display("FAIL oneshot_step%0d: got count=%0d out=%b expected count=%0d out=%b",
                         i, b0.counter_out, b0.counter0_out, 5 - i, (i == 5));
            end
            next_cycle();
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'd0 || b0.counter0_out !== 1'b1) begin
                n_bad++;
                $display("FAIL oneshot_hold%0d: got count=%0d out=%b expected count=0 out=1",
                         i, b0.counter_out, b0.counter0_out);
            end
            next_cycle();
        end
        set_addr(0, 2'b11);
        n_cmp++;
        if (b0.counter_out !== 32'h0000_2004) begin
            n_bad++; $display("FAIL oneshot_ctrl_read: got %h expected 00002004", b0.counter_out);
        end
    endtask

    task automatic test_periodic();
        int highs = 0;
        wr(0, 2'b11, 32'h050);
        wr(0, 2'b01, 32'd3);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'(3 - (i % 3)) || b0.counter1_out !== (i > 0 && i % 3 == 0)) begin
                n_bad++;
                $display("FAIL periodic_step%0d: got count=%0d out=%b expected count=%0d out=%b",
                         i, b0.counter_out, b0.counter1_out, 3 - (i % 3), (i > 0 && i % 3 == 0));
            end
            if (b0.counter1_out === 1'b1) highs++;
            next_cycle();
        end
        n_cmp++;
        if (highs != 3) begin
            n_bad++; $display("FAIL periodic_pulse_count: got %0d expected 3", highs);
        end
    endtask

    task automatic test_square();
        wr(0, 2'b11, 32'h600);
        wr(0, 2'b10, 32'd4);
        for (int i = 0; i < 22; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'(4 - (i % 4)) || b0.counter2_out !== 1'((i / 4) % 2)) begin
                n_bad++;
                $display("FAIL square_step%0d: got count=%0d out=%b expected count=%0d out=%0d",
                         i, b0.counter_out, b0.counter2_out, 4 - (i % 4), (i / 4) % 2);
            end
            next_cycle();
        end
        wr(0, 2'b11, 32'h200);
        set_addr(0, 2'b10);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'd1 || b0.counter2_out !== 1'b1) begin
                n_bad++;
                $display("FAIL square_freeze%0d: got count=%0d out=%b expected count=1 out=1",
                         i, b0.counter_out, b0.counter2_out);
            end
            next_cycle();
        end
    endtask

    task automatic test_mode_change();
        wr(0, 2'b11, 32'h006);
        wr(0, 2'b00, 32'd4);
        repeat (5) next_cycle();
        wr(0, 2'b11, 32'h002);
        set_addr(0, 2'b00);
        n_cmp++;
        if (b0.counter_out !== 32'd2 || b0.counter0_out !== 1'b1) begin
            n_bad++; $display("FAIL mode_pre: got count=%0d out=%b expected count=2 out=1",
                              b0.counter_out, b0.counter0_out);
        end
        wr(0, 2'b11, 32'h000);
        set_addr(0, 2'b00);
        n_cmp++;
        if (b0.counter_out !== 32'd2 || b0.counter0_out !== 1'b0) begin
            n_bad++; $display("FAIL mode_clear: got count=%0d out=%b expected count=2 out=0",
                              b0.counter_out, b0.counter0_out);
        end
        set_addr(0, 2'b11);
        n_cmp++;
        if (b0.counter_out !== 32'h0) begin
            n_bad++; $display("FAIL mode_ctrl_read: got %h expected 00000000", b0.counter_out);
        end
    endtask

    task automatic test_collision();
        wr(0, 2'b11, 32'h004);
        wr(0, 2'b00, 32'd1);
        wr(0, 2'b00, 32'd7);
        n_cmp++;
        if (b0.counter_out !== 32'd7 || b0.counter0_out !== 1'b0) begin
            n_bad++; $display("FAIL collision_write: got count=%0d out=%b expected count=7 out=0",
                              b0.counter_out, b0.counter0_out);
        end
        next_cycle();
        n_cmp++;
        if (b0.counter_out !== 32'd6 || b0.counter0_out !== 1'b0) begin
            n_bad++; $display("FAIL collision_next: got count=%0d out=%b expected count=6 out=0",
                              b0.counter_out, b0.counter0_out);
        end
    endtask

    task automatic test_reload0();
        wr(0, 2'b11, 32'h005);
        wr(0, 2'b00, 32'd0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (b0.counter_out !== 32'd0 || b0.counter0_out !== 1'b0) begin
                n_bad++; $display("FAIL reload0_step%0d: got count=%0d out=%b expected count=0 out=0",
                                  i, b0.counter_out, b0.counter0_out);
            end
            next_cycle();
        end
    endtask

    task automatic test_prescaler();
        int d1 = -1;
        int d2 = -1;
        int rise = -1;
        logic [31:0] prev = 32'd2;
        wr(1, 2'b11, 32'h004);
        wr(1, 2'b00, 32'd2);
        n_cmp++;
        if (b1.counter_out !== 32'd2) begin
            n_bad++; $display("FAIL presc_start: got %0d expected 2", b1.counter_out);
        end
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            if (b1.counter_out !== prev) begin
                n_cmp++;
                if (b1.counter_out !== prev - 32'd1) begin
                    n_bad++; $display("FAIL presc_dec c=%0d: got %0d expected %0d",
                                      c, b1.counter_out, prev - 32'd1);
                end
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
                prev = b1.counter_out;
            end
            if (rise < 0 && b1.counter0_out === 1'b1) rise = c;
        end
        n_cmp++;
        if (d1 < 1 || d1 > 4) begin
            n_bad++; $display("FAIL presc_first_tick: got %0d expected 1..4", d1);
        end
        n_cmp++;
        if (d2 != d1 + 4) begin
            n_bad++; $display("FAIL presc_spacing: got %0d expected %0d", d2, d1 + 4);
        end
        n_cmp++;
        if (rise < 5 || rise > 8 || rise != d2) begin
            n_bad++; $display("FAIL presc_rise: got %0d expected 5..8 and equal to %0d", rise, d2);
        end
    endtask

    task automatic test_reset_mid();
        wr(0, 2'b11, 32'h050);
        wr(0, 2'b01, 32'd3);
        repeat (2) next_cycle();
        rst = 1'b1;
        b0.counter_we = 1'b1; b0.addr = 2'b01; b0.Peripheral_in = $urandom;
        b1.counter_we = 1'b1; b1.addr = 2'b00; b1.Peripheral_in = $urandom;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b0.counter_we = 1'b0;
        b1.counter_we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            set_addr(0, 2'(a));
            set_addr(1, 2'(a));
            n_cmp++;
            if (b0.counter_out !== 32'h0 || b1.counter_out !== 32'h0) begin
                n_bad++; $display("FAIL rstmid_read addr=%0d: got %h/%h expected 0/0",
                                  a, b0.counter_out, b1.counter_out);
            end
        end
        n_cmp++;
        if ({get_out(1), get_out(0)} !== 6'b0) begin
            n_bad++; $display("FAIL rstmid_outs: got %b expected 000000", {get_out(1), get_out(0)});
        end
    endtask

    task automatic test_random();
        logic [1:0] a;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                a = 2'($urandom_range(0, 3));
                if (i == 0) begin
                    b0.counter_we = ($urandom_range(0, 3) == 0);
                    b0.addr = a;
                    b0.Peripheral_in = (a == 2'b11) ? $urandom : 32'($urandom_range(0, 6));
                end else begin
                    b1.counter_we = ($urandom_range(0, 3) == 0);
                    b1.addr = a;
                    b1.Peripheral_in = (a == 2'b11) ? $urandom : 32'($urandom_range(0, 6));
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                a = (i == 0) ? b0.addr : b1.addr;
                n_cmp++;
                if (get_rd(i) !== m_read(i, a)) begin
                    n_bad++; $display("FAIL rand_read inst=%0d cyc=%0d addr=%0d: got %h expected %h",
                                      i, cyc, a, get_rd(i), m_read(i, a));
                end
                n_cmp++;
                if (get_out(i) !== m_out[i]) begin
                    n_bad++; $display("FAIL rand_outs inst=%0d cyc=%0d: got %b expected %b",
                                      i, cyc, get_out(i), m_out[i]);
                end
            end
            @(negedge clk);
        end
        b0.counter_we = 1'b0;
        b1.counter_we = 1'b0;
        #1;
    endtask

    initial begin
        b0.counter_we = 1'b0; b0.addr = 2'b00; b0.Peripheral_in = 32'h0;
        b1.counter_we = 1'b0; b1.addr = 2'b00; b1.Peripheral_in = 32'h0;
        rst = 1'b1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_square();
        test_mode_change();
        test_collision();
        test_reload0();
        test_prescaler();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mio_counter3.md
# mio_counter3

Three-channel programmable timer peripheral that sits on the responder side of the MIO bus decoder. It accepts bus writes qualified by `counter_we` with data on `Peripheral_in`, and returns register contents on `counter_out`. It also drives three per-channel status/waveform outputs, `counter0_out` to `counter2_out`, which the decoder exposes to the CPU and to the GPIO/LED paths.

## Interface
- PRESCALE, 1: clk cycles per count tick; legal range 1..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- counter_we  in  1  write strobe from the bus decoder; one write per cycle in which it is high.
- addr  in  2  register select, taken from addr_bus[3:2]. 00 = ch0, 01 = ch1, 10 = ch2, 11 = control.
- Peripheral_in  in  32  write data from the bus.
- counter_out  out  32  read data for the register selected by `addr`.
- counter0_out, counter1_out, counter2_out  out  1 each  channel outputs (flag, pulse or square wave, depending on mode).

## Operation
- **Per-channel state (n = 0..2):** reload[n] (32 bits), count[n] (32 bits), out[n] (1 bit).
- **Control register (32 bits):**
  - [1:0] mode0, [2] en0
  - [5:4] mode1, [6] en1
  - [9:8] mode2, [10] en2
  - All other bits are read as 0 and ignored on write.
  - Modes: 00 one-shot, 01 periodic pulse, 10 square wave, 11 behaves as 00.
- **Prescaler:** 16-bit, free-running. Counts 0..PRESCALE-1, then wraps to 0. `tick` is high for the one cycle in which the prescaler equals PRESCALE-1. Only rst clears the prescaler; writes do not.
- **Channel write** (counter_we=1, addr=n):
  - reload[n] ← data, count[n] ← data, out[n] ← 0.
  - The write has priority over any tick in the same cycle.
- **Control write** (counter_we=1, addr=11):
  - Updates the mode and enable fields.
  - Counts are left unchanged.
  - out[n] ← 0 for every channel whose mode field changes value.
- **Counting:** on a cycle with tick=1, en[n]=1 and no write to channel n:
  - One-shot:
    - If count≠0: count ← count-1.
    - If count was 1: out ← 1.
    - out stays 1, and count holds at 0, until the next channel write.
  - Periodic:
    - If count>1: count ← count-1, out ← 0.
    - If count≤1 and reload≠0: count ← reload, out ← 1 (for one tick only).
    - If reload=0: count and out hold at 0.
  - Square:
    - Same count behaviour as periodic.
    - On reload, out ← ~out instead of pulsing.
    - If reload=0, out holds.
- **Disabled channel** (en=0): count and out hold.
- **Read mux (combinational, same cycle):**
  - addr 00/01/10: returns count[n].
  - addr 11: returns {control[31:11]=0, control[10:0]} with bits [15:13] replaced by {out2, out1, out0}.
- **Arithmetic:** all count arithmetic is unsigned 32-bit. Decrement from 0 never occurs, because the count>1/≠0 guards above prevent it.

## Timing
- **Reset:**
  - All reload, count, out, control and prescaler registers ← 0.
  - Outputs after reset: counter_out = 0, counter0_out..counter2_out = 0.
- **Write latency:** a write sampled at edge k is visible on counter_out and the channel outputs after edge k.
- **One-shot, PRESCALE=1, channel already enabled, write N≥1 at edge k:** out rises at edge k+N.
- **Periodic / square, PRESCALE=1, write N:**
  - Pulse (or toggle) at edges k+N, k+2N, k+3N, …
  - Periodic: pulse width 1 clk.
  - Square: period 2N clk.
- **Prescaled operation:** with PRESCALE=P, each decrement needs a tick. Latency is N ticks, with the first tick landing 1..P cycles after the write.
- **Periodic pulse width:** with P>1 the out register holds its value until the next tick, so the pulse width is P clk.
- **Write during pulse:** a write to a channel in the same cycle as its pulse clears out in the next cycle.
- **Reset mid-count:** rst wins over writes and ticks, and all state returns to reset values at that edge.

## Test plan
- **Reset check:**
  - Stimulus: rst=1 for 2 cycles with counter_we=1 and random data.
  - Required: all outputs 0; reads of all 4 addresses return 0.
- **One-shot:**
  - Stimulus: PRESCALE=1; control=0x004; write ch0=5 at edge k.
  - Required: count0 reads 5,4,3,2,1,0. counter0_out rises at edge k+5 and stays 1 for 20 more cycles. Reading addr 11 shows bit13=1.
- **Periodic:**
  - Stimulus: control=0x050 (mode1=01, en1=1); write ch1=3.
  - Required: counter1_out is high exactly 1 cycle in every 3; count reads 3,2,1,3,2,1…
- **Square:**
  - Stimulus: control=0x600 (mode2=10, en2=1); write ch2=4.
  - Required: counter2_out toggles every 4 cycles (period 8). Setting en2=0 freezes count and out.
- **Collision and edge cases:**
  - Write ch0=7 in the same cycle as the tick that would expire it: count becomes 7 and out stays 0.
  - Periodic with reload 0: out never pulses.
  - Control write changing mode0: clears out0 without altering count0.
- **Prescaler:**
  - Stimulus: PRESCALE=4; one-shot ch0=2 written with en0=1.
  - Required: count0 decrements only on ticks spaced 4 cycles apart; out0 rises between 5 and 8 cycles after the write.
